// File: rtl/word_row_cache_pkg.sv
// word_row_cache_pkg: shared widths and FSM state encoding for the row cache
package word_row_cache_pkg;
  localparam int ROWINDEXBITS = 4;
  localparam int COLINDEXBITS = 2;
  localparam int LETTERBITS = 8;
  localparam int ROWWIDTH = (1 << COLINDEXBITS) * LETTERBITS;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    RESPOND = 2'd2
  } state_t;
endpackage

// File: rtl/word_row_cache_if.sv
// word_row_cache_if: request, memory fetch and response signals of the row cache
interface word_row_cache_if;
  import word_row_cache_pkg::*;
  logic inValid;
  logic inReady;
  logic [ROWINDEXBITS-1:0] wordIndex;
  logic [COLINDEXBITS-1:0] letterIndex;
  logic invalidate;
  logic memReq;
  logic [ROWINDEXBITS-1:0] memRowAddr;
  logic memAck;
  logic [ROWWIDTH-1:0] memRowData;
  logic outValid;
  logic outReady;
  logic [LETTERBITS-1:0] outLetter;
  logic [ROWINDEXBITS-1:0] outWordIndex;
  logic [COLINDEXBITS-1:0] outLetterIndex;
  modport slave (
    input  inValid, wordIndex, letterIndex, invalidate, memAck, memRowData, outReady,
    output inReady, memReq, memRowAddr, outValid, outLetter, outWordIndex, outLetterIndex
  );
  modport master (
    output inValid, wordIndex, letterIndex, invalidate, memAck, memRowData, outReady,
    input  inReady, memReq, memRowAddr, outValid, outLetter, outWordIndex, outLetterIndex
  );
endinterface

// File: rtl/word_row_cache_row_letter_select.sv
// row_letter_select: picks one letter slice out of a packed row
module row_letter_select
  import word_row_cache_pkg::*;
(
  input  logic [ROWWIDTH-1:0]     row,
  input  logic [COLINDEXBITS-1:0] letterIndex,
  output logic [LETTERBITS-1:0]   letter
);
  // letter j lives at bits [j*LETTERBITS +: LETTERBITS]
  always_comb letter = row[letterIndex*LETTERBITS +: LETTERBITS];
endmodule

// File: rtl/word_row_cache.sv
// word_row_cache: single-row letter cache with req/ack row refill and saturating hit/miss counters
module word_row_cache
  import word_row_cache_pkg::*;
#(
  parameter int COUNTBITS = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  word_row_cache_if.slave      bus,
  output logic [COUNTBITS-1:0] hitCount,
  output logic [COUNTBITS-1:0] missCount
);
  state_t state;
  logic cacheValid;
  logic invalSeen;
  logic [ROWINDEXBITS-1:0] cachedRow;
  logic [ROWWIDTH-1:0] rowBuf;
  logic [ROWINDEXBITS-1:0] reqWord;
  logic [COLINDEXBITS-1:0] reqLetter;
  logic hit;
  logic [ROWWIDTH-1:0] selRow;
  logic [COLINDEXBITS-1:0] selIdx;
  logic [LETTERBITS-1:0] selLetter;

  assign bus.inReady = state == IDLE;

  // hits read the held row with the live index; refills read the incoming row with the captured index
  always_comb begin
    hit = cacheValid && !bus.invalidate && bus.wordIndex == cachedRow;
    selRow = state == FETCH ? bus.memRowData : rowBuf;
    selIdx = state == FETCH ? reqLetter : bus.letterIndex;
  end

  row_letter_select u_sel (
    .row(selRow),
    .letterIndex(selIdx),
    .letter(selLetter)
  );

  // request FSM: accept, refill on miss, then hold the response until taken
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cacheValid <= 1'b0;
      invalSeen <= 1'b0;
      cachedRow <= '0;
      rowBuf <= '0;
      reqWord <= '0;
      reqLetter <= '0;
      bus.memReq <= 1'b0;
      bus.memRowAddr <= '0;
      bus.outValid <= 1'b0;
      bus.outLetter <= '0;
      bus.outWordIndex <= '0;
      bus.outLetterIndex <= '0;
      hitCount <= '0;
      missCount <= '0;
    end else begin
      if (bus.invalidate) cacheValid <= 1'b0;
      case (state)
        IDLE: if (bus.inValid) begin
          reqWord <= bus.wordIndex;
          reqLetter <= bus.letterIndex;
          if (hit) begin
            state <= RESPOND;
            bus.outValid <= 1'b1;
            bus.outLetter <= selLetter;
            bus.outWordIndex <= bus.wordIndex;
            bus.outLetterIndex <= bus.letterIndex;
            if (hitCount != '1) hitCount <= hitCount + 1'b1;
          end else begin
            state <= FETCH;
            bus.memReq <= 1'b1;
            bus.memRowAddr <= bus.wordIndex;
            invalSeen <= 1'b0;
            if (missCount != '1) missCount <= missCount + 1'b1;
          end
        end
        FETCH: begin
          invalSeen <= invalSeen | bus.invalidate;
          if (bus.memAck) begin
            rowBuf <= bus.memRowData;
            cachedRow <= bus.memRowAddr;
            cacheValid <= !(invalSeen || bus.invalidate);
            bus.memReq <= 1'b0;
            state <= RESPOND;
            bus.outValid <= 1'b1;
            bus.outLetter <= selLetter;
            bus.outWordIndex <= reqWord;
            bus.outLetterIndex <= reqLetter;
          end
        end
        RESPOND: if (bus.outReady) begin
          state <= IDLE;
          bus.outValid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_word_row_cache.sv
// tb_word_row_cache: directed checks of hit/miss, backpressure, invalidate, reset and counter saturation
module tb_word_row_cache;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int checks = 0;
  int failures = 0;
  logic [15:0] hit16, miss16;
  logic [3:0] hit4, miss4;

  word_row_cache_if bus();
  word_row_cache_if bus4();

  assign bus4.inValid = bus.inValid;
  assign bus4.wordIndex = bus.wordIndex;
  assign bus4.letterIndex = bus.letterIndex;
  assign bus4.invalidate = bus.invalidate;
  assign bus4.memAck = bus.memAck;
  assign bus4.memRowData = bus.memRowData;
  assign bus4.outReady = bus.outReady;

  word_row_cache dut (.clock(clock), .reset_n(reset_n), .bus(bus.slave), .hitCount(hit16), .missCount(miss16));
  word_row_cache #(.COUNTBITS(4)) dut4 (.clock(clock), .reset_n(reset_n), .bus(bus4.slave), .hitCount(hit4), .missCount(miss4));

  always #5 clock = ~clock;

  task automatic test_reset;
    bus.inValid = 0; bus.wordIndex = 0; bus.letterIndex = 0; bus.invalidate = 0;
    bus.memAck = 0; bus.memRowData = 0; bus.outReady = 1;
    reset_n = 0;
    repeat (3) @(negedge clock);
    checks++; if (bus.inReady !== 1'b1) begin failures++; $display("FAIL rst_inReady got %b exp 1", bus.inReady); end
    checks++; if (bus.memReq !== 1'b0) begin failures++; $display("FAIL rst_memReq got %b exp 0", bus.memReq); end
    checks++; if (bus.outValid !== 1'b0) begin failures++; $display("FAIL rst_outValid got %b exp 0", bus.outValid); end
    checks++; if (hit16 !== 16'd0 || miss16 !== 16'd0) begin failures++; $display("FAIL rst_counts got %h/%h exp 0/0", hit16, miss16); end
    bus.memAck = 1; bus.memRowData = 32'hFFFFFFFF;
    reset_n = 1;
    repeat (2) @(negedge clock);
    checks++; if (bus.outValid !== 1'b0 || bus.memReq !== 1'b0) begin failures++; $display("FAIL stray_ack_ctl got %b%b exp 00", bus.outValid, bus.memReq); end
    checks++; if (bus.outLetter !== 8'h00 || bus.memRowAddr !== 4'h0 || bus.outWordIndex !== 4'h0 || bus.outLetterIndex !== 2'h0) begin
      failures++; $display("FAIL stray_ack_data got %h %h %h %h exp 0", bus.outLetter, bus.memRowAddr, bus.outWordIndex, bus.outLetterIndex); end
    checks++; if (bus.inReady !== 1'b1) begin failures++; $display("FAIL stray_ack_inReady got %b exp 1", bus.inReady); end
    bus.memAck = 0; bus.memRowData = 0;
  endtask

  task automatic test_cold_miss;
    bus.inValid = 1; bus.wordIndex = 3; bus.letterIndex = 2;
    @(negedge clock);
    bus.inValid = 0;
    checks++; if (bus.memReq !== 1'b1 || bus.memRowAddr !== 4'd3) begin failures++; $display("FAIL miss_req got %b/%h exp 1/3", bus.memReq, bus.memRowAddr); end
    checks++; if (miss16 !== 16'd1) begin failures++; $display("FAIL miss_count got %0d exp 1", miss16); end
    checks++; if (bus.inReady !== 1'b0 || bus.outValid !== 1'b0) begin failures++; $display("FAIL miss_busy got %b%b exp 00", bus.inReady, bus.outValid); end
    @(negedge clock);
    checks++; if (bus.memReq !== 1'b1 || bus.memRowAddr !== 4'd3) begin failures++; $display("FAIL miss_req_hold got %b/%h exp 1/3", bus.memReq, bus.memRowAddr); end
    bus.memAck = 1; bus.memRowData = 32'h44332211;
    @(negedge clock);
    bus.memAck = 0;
    checks++; if (bus.outValid !== 1'b1 || bus.outLetter !== 8'h33) begin failures++; $display("FAIL miss_resp got %b/%h exp 1/33", bus.outValid, bus.outLetter); end
    checks++; if (bus.outWordIndex !== 4'd3 || bus.outLetterIndex !== 2'd2) begin failures++; $display("FAIL miss_echo got %h/%h exp 3/2", bus.outWordIndex, bus.outLetterIndex); end
    checks++; if (bus.memReq !== 1'b0) begin failures++; $display("FAIL miss_req_drop got %b exp 0", bus.memReq); end
    @(negedge clock);
    checks++; if (bus.outValid !== 1'b0 || bus.inReady !== 1'b1) begin failures++; $display("FAIL miss_done got %b%b exp 01", bus.outValid, bus.inReady); end
  endtask

  task automatic test_hit;
    bus.inValid = 1; bus.wordIndex = 3; bus.letterIndex = 0;
    @(negedge clock);
    bus.inValid = 0;
    checks++; if (bus.memReq !== 1'b0) begin failures++; $display("FAIL hit_noreq got %b exp 0", bus.memReq); end
    checks++; if (bus.outValid !== 1'b1 || bus.outLetter !== 8'h11) begin failures++; $display("FAIL hit_resp got %b/%h exp 1/11", bus.outValid, bus.outLetter); end
    checks++; if (bus.outWordIndex !== 4'd3 || bus.outLetterIndex !== 2'd0) begin failures++; $display("FAIL hit_echo got %h/%h exp 3/0", bus.outWordIndex, bus.outLetterIndex); end
    checks++; if (hit16 !== 16'd1 || miss16 !== 16'd1) begin failures++; $display("FAIL hit_count got %0d/%0d exp 1/1", hit16, miss16); end
    @(negedge clock);
  endtask

  task automatic test_backpressure;
    bus.outReady = 0;
    bus.inValid = 1; bus.wordIndex = 3; bus.letterIndex = 3;
    @(negedge clock);
    bus.inValid = 0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (bus.outValid !== 1'b1 || bus.outLetter !== 8'h44 || bus.outWordIndex !== 4'd3 || bus.outLetterIndex !== 2'd3 || bus.inReady !== 1'b0) begin
        failures++; $display("FAIL bp_hold%0d got v=%b l=%h w=%h i=%h r=%b exp v=1 l=44 w=3 i=3 r=0", i, bus.outValid, bus.outLetter, bus.outWordIndex, bus.outLetterIndex, bus.inReady); end
      @(negedge clock);
    end
    bus.outReady = 1;
    @(negedge clock);
    checks++; if (bus.outValid !== 1'b0 || bus.inReady !== 1'b1) begin failures++; $display("FAIL bp_release got %b%b exp 01", bus.outValid, bus.inReady); end
    checks++; if (hit16 !== 16'd2) begin failures++; $display("FAIL bp_count got %0d exp 2", hit16); end
  endtask

  task automatic test_invalidate;
    bus.inValid = 1; bus.wordIndex = 3; bus.letterIndex = 1; bus.invalidate = 1;
    @(negedge clock);
    bus.inValid = 0; bus.invalidate = 0;
    checks++; if (bus.memReq !== 1'b1 || bus.memRowAddr !== 4'd3) begin failures++; $display("FAIL inv_miss got %b/%h exp 1/3", bus.memReq, bus.memRowAddr); end
    checks++; if (miss16 !== 16'd2 || hit16 !== 16'd2) begin failures++; $display("FAIL inv_count got %0d/%0d exp 2/2", miss16, hit16); end
    bus.memAck = 1; bus.memRowData = 32'hDDCCBBAA;
    @(negedge clock);
    bus.memAck = 0;
    checks++; if (bus.outValid !== 1'b1 || bus.outLetter !== 8'hBB) begin failures++; $display("FAIL inv_fast_ack got %b/%h exp 1/bb", bus.outValid, bus.outLetter); end
    @(negedge clock);
    bus.inValid = 1; bus.wordIndex = 7; bus.letterIndex = 0;
    @(negedge clock);
    bus.inValid = 0; bus.invalidate = 1;
    @(negedge clock);
    bus.invalidate = 0; bus.memAck = 1; bus.memRowData = 32'h000000EE;
    @(negedge clock);
    bus.memAck = 0;
    checks++; if (bus.outValid !== 1'b1 || bus.outLetter !== 8'hEE) begin failures++; $display("FAIL inv_fetch_serve got %b/%h exp 1/ee", bus.outValid, bus.outLetter); end
    @(negedge clock);
    bus.inValid = 1; bus.wordIndex = 7; bus.letterIndex = 0;
    @(negedge clock);
    bus.inValid = 0;
    checks++; if (bus.memReq !== 1'b1 || bus.outValid !== 1'b0 || miss16 !== 16'd4) begin
      failures++; $display("FAIL inv_fetch_notvalid got req=%b v=%b miss=%0d exp 1/0/4", bus.memReq, bus.outValid, miss16); end
    bus.memAck = 1; bus.memRowData = 32'h000000EE;
    @(negedge clock);
    bus.memAck = 0;
    @(negedge clock);
  endtask

  task automatic test_reset_mid_fetch;
    bus.inValid = 1; bus.wordIndex = 9; bus.letterIndex = 0;
    @(negedge clock);
    bus.inValid = 0;
    checks++; if (bus.memReq !== 1'b1) begin failures++; $display("FAIL mid_req got %b exp 1", bus.memReq); end
    @(negedge clock);
    bus.memAck = 1; bus.memRowData = 32'h12345678;
    #2 reset_n = 0;
    #1;
    checks++; if (bus.memReq !== 1'b0 || bus.outValid !== 1'b0) begin failures++; $display("FAIL mid_async got %b%b exp 00", bus.memReq, bus.outValid); end
    @(negedge clock);
    reset_n = 1;
    @(negedge clock);
    bus.memAck = 0;
    checks++; if (bus.outValid !== 1'b0 || bus.memReq !== 1'b0 || hit16 !== 16'd0 || miss16 !== 16'd0) begin
      failures++; $display("FAIL mid_after got v=%b r=%b h=%0d m=%0d exp 0/0/0/0", bus.outValid, bus.memReq, hit16, miss16); end
    bus.inValid = 1; bus.wordIndex = 3; bus.letterIndex = 1;
    @(negedge clock);
    bus.inValid = 0;
    checks++; if (bus.memReq !== 1'b1 || bus.memRowAddr !== 4'd3 || miss16 !== 16'd1) begin
      failures++; $display("FAIL mid_remiss got r=%b a=%h m=%0d exp 1/3/1", bus.memReq, bus.memRowAddr, miss16); end
    bus.memAck = 1; bus.memRowData = 32'h44332211;
    @(negedge clock);
    bus.memAck = 0;
    checks++; if (bus.outLetter !== 8'h22) begin failures++; $display("FAIL mid_letter got %h exp 22", bus.outLetter); end
    @(negedge clock);
  endtask

  task automatic test_saturate;
    bus.inValid = 1; bus.wordIndex = 3; bus.letterIndex = 1;
    repeat (40) @(negedge clock);
    bus.inValid = 0;
    checks++; if (hit16 !== 16'd20) begin failures++; $display("FAIL sat_hit16 got %0d exp 20", hit16); end
    checks++; if (hit4 !== 4'hF) begin failures++; $display("FAIL sat_hit4 got %h exp f", hit4); end
    checks++; if (miss4 !== 4'd1 || miss16 !== 16'd1) begin failures++; $display("FAIL sat_miss got %0d/%0d exp 1/1", miss4, miss16); end
    @(negedge clock);
    checks++; if (bus.outValid !== 1'b0 || bus.inReady !== 1'b1) begin failures++; $display("FAIL sat_idle got %b%b exp 01", bus.outValid, bus.inReady); end
  endtask

  initial begin
    test_reset;
    test_cold_miss;
    test_hit;
    test_backpressure;
    test_invalidate;
    test_reset_mid_fetch;
    test_saturate;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
